stdp_weight_writer: RTL and testbench
=====================================

STDP_WEIGHT_WRITER -- requirements
Module: stdp_weight_writer

Interface
REQ-001 Parameter W_MAX, default 255: upper weight saturation bound.
REQ-002 Parameter W_MIN, default 0: lower weight saturation bound.
REQ-003 Parameter A_LTP, default 32: potentiation base step.
REQ-004 Parameter A_LTD, default 16: depression base step.
REQ-005 Parameter TIMEOUT, default 15: maximum RD_WAIT cycles.
REQ-006 The block SHALL have one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst  in  1  synchronous active-low reset.
REQ-009 kill  in  1  synchronous abort of the current update.
REQ-010 upd_valid/upd_ready  in/out  1/1  update-request handshake.
REQ-011 upd_neuron  in  7  target neuron number; upd_ltp  in  1  1=potentiate, 0=depress; upd_dt  in  4  spike time difference.
REQ-012 rd_req  out  1, rd_neuron  out  7, rd_valid  in  1, rd_weight  in  8: weight read from the synapse table.
REQ-013 wr_req  out  1, wr_neuron  out  7, wr_weight  out  8, wr_ack  in  1: weight write-back to the synapse table.
REQ-014 busy  out  1, done  out  1, error  out  1, upd_count  out  16.

Function
REQ-015 The FSM SHALL have states IDLE, RD_REQ, RD_WAIT, CALC, WR, FIN.
REQ-016 upd_ready SHALL be 1 only in IDLE with kill=0; busy SHALL be 1 in every state except IDLE.
REQ-017 On upd_valid&upd_ready, upd_neuron/upd_ltp/upd_dt SHALL be captured and the FSM SHALL go to RD_REQ.
REQ-018 RD_REQ: rd_req=1 for exactly one cycle, rd_neuron=captured neuron; next state RD_WAIT.
REQ-019 RD_WAIT: on rd_valid=1, rd_weight SHALL be captured -> CALC; rd_valid in any other state SHALL be ignored.
REQ-020 RD_WAIT lasting TIMEOUT cycles without rd_valid -> error=1 for one cycle, -> IDLE, no write.
REQ-021 CALC (one cycle): step = (upd_ltp ? A_LTP : A_LTD) >> upd_dt, 8-bit; dt>=8 yields step 0.
REQ-022 LTP: new = min(w+step, W_MAX) computed 9 bits wide; LTD: new = max(w-step, W_MIN) computed signed 10 bits, with no wrap.
REQ-023 step=0 -> skip WR, go to FIN (done pulses, no write, upd_count unchanged).
REQ-024 WR: wr_req, wr_neuron, wr_weight held stable until wr_ack=1 sampled -> FIN; wr_ack outside WR ignored.
REQ-025 FIN: done=1 for one cycle -> IDLE; back-to-back acceptance possible on the following cycle.
REQ-026 Minimum latency: accept cycle 0, rd_req cycle 1, rd_valid cycle 2, CALC cycle 3, wr_req+wr_ack cycle 4, done cycle 5.
REQ-027 kill=1 in any state -> IDLE next cycle; rd_req/wr_req deasserted; no done and no error for the aborted update.
REQ-028 kill and upd_valid together: request not accepted.

Reset
REQ-029 rst=0 at a clock edge SHALL force IDLE from any state, including mid-write, and takes priority over kill.
REQ-030 Reset values: upd_ready=1 after release, rd_req=0, wr_req=0, rd_neuron=0, wr_neuron=0, wr_weight=0, busy=0, done=0, error=0, upd_count=0.

Configuration
REQ-031 With STDP_UPD_COUNT_EN defined, upd_count SHALL increment by 1 on each wr_ack accepted in WR, wrapping 0xFFFF->0x0000.
REQ-032 Without STDP_UPD_COUNT_EN, upd_count SHALL be constant 0 and no counter logic SHALL exist; the port list is unchanged.

Verification
REQ-033 Issue LTP, neuron 5, dt=1, rd_weight=100, wr_ack immediate -> wr_neuron=5, wr_weight=116, done at cycle 5.
REQ-034 Issue LTP, dt=0, rd_weight=250 -> wr_weight=255; LTD, dt=0, rd_weight=10 -> wr_weight=0.
REQ-035 Issue dt=9 -> no wr_req, done pulses, upd_count unchanged.
REQ-036 Withhold rd_valid for 15 cycles -> error pulse, back in IDLE, no wr_req; kill asserted during WR -> wr_req low next cycle, no done.
REQ-037 With STDP_UPD_COUNT_EN, preload upd_count to 0xFFFF and complete one write -> 0x0000; apply rst=0 mid-RD_WAIT -> all reset values on the next edge.

Source files
------------

// File: rtl/stdp_weight_writer_if.sv
// STDP weight writer bus: update request, synapse table read and write-back.
// slave = writer side, master = requester / synapse table side.
interface stdp_weight_writer_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [6:0] upd_neuron;
  logic       upd_ltp;
  logic [3:0] upd_dt;

  logic       rd_req;
  logic [6:0] rd_neuron;
  logic       rd_valid;
  logic [7:0] rd_weight;

  logic       wr_req;
  logic [6:0] wr_neuron;
  logic [7:0] wr_weight;
  logic       wr_ack;

  modport slave (
    input  upd_valid,
    output upd_ready,
    input  upd_neuron,
    input  upd_ltp,
    input  upd_dt,
    output rd_req,
    output rd_neuron,
    input  rd_valid,
    input  rd_weight,
    output wr_req,
    output wr_neuron,
    output wr_weight,
    input  wr_ack
  );

  modport master (
    output upd_valid,
    input  upd_ready,
    output upd_neuron,
    output upd_ltp,
    output upd_dt,
    input  rd_req,
    input  rd_neuron,
    output rd_valid,
    output rd_weight,
    input  wr_req,
    input  wr_neuron,
    input  wr_weight,
    output wr_ack
  );
endinterface

// File: rtl/stdp_weight_writer.sv
// STDP weight writer: read-modify-write of one synapse weight per update.
// Ports: clk, rst (sync, active-low), kill (abort), bus (stdp_weight_writer_if.slave),
//   busy, done, error (read timeout), upd_count (writes; needs STDP_UPD_COUNT_EN, else 0).
module stdp_weight_writer #(
  parameter int W_MAX   = 255,
  parameter int W_MIN   = 0,
  parameter int A_LTP   = 32,
  parameter int A_LTD   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kill,
  stdp_weight_writer_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] upd_count
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [8:0] WMAX9 = 9'(W_MAX);
  localparam logic signed [9:0] WMIN10 = 10'(W_MIN);
  localparam logic [7:0] STEP_LTP = 8'(A_LTP);
  localparam logic [7:0] STEP_LTD = 8'(A_LTD);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CALC,
    WR,
    FIN
  } state_t;

  state_t st_q, st_d;

  logic [6:0]    nrn_q;
  logic          ltp_q;
  logic [3:0]    dt_q;
  logic [7:0]    w_q;
  logic [7:0]    new_q;
  logic [TW-1:0] tmo_q;

  logic        ready;
  logic        accept;
  logic [7:0]  base;
  logic [7:0]  step;
  logic [8:0]  sum;
  logic signed [9:0] diff;
  logic [7:0]  new_w;

  assign ready  = (st_q == IDLE) && !kill;
  assign accept = bus.upd_valid && ready;

  assign bus.upd_ready = ready;
  assign bus.rd_req    = (st_q == RD_REQ);
  assign bus.rd_neuron = nrn_q;
  assign bus.wr_req    = (st_q == WR);
  assign bus.wr_neuron = nrn_q;
  assign bus.wr_weight = new_q;

  assign busy = (st_q != IDLE);

  // Step is an 8-bit shift; any dt of 8 or more empties it.
  always_comb begin
    base  = ltp_q ? STEP_LTP : STEP_LTD;
    step  = dt_q[3] ? 8'd0 : (base >> dt_q[2:0]);
    sum   = {1'b0, w_q} + {1'b0, step};
    diff  = $signed({2'b00, w_q}) - $signed({2'b00, step});
    new_w = w_q;
    if (ltp_q) begin
      new_w = (sum > WMAX9) ? WMAX9[7:0] : sum[7:0];
    end else begin
      new_w = (diff < WMIN10) ? WMIN10[7:0] : diff[7:0];
    end
  end

  always_comb begin
    st_d  = st_q;
    done  = 1'b0;
    error = 1'b0;
    case (st_q)
      IDLE: begin
        if (accept) st_d = RD_REQ;
      end
      RD_REQ: begin
        st_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.rd_valid) begin
          st_d = CALC;
        end else if (tmo_q == TMO_LAST) begin
          error = 1'b1;
          st_d  = IDLE;
        end
      end
      CALC: begin
        st_d = (step == 8'd0) ? FIN : WR;
      end
      WR: begin
        if (bus.wr_ack) st_d = FIN;
      end
      FIN: begin
        done = 1'b1;
        st_d = IDLE;
      end
      default: begin
        st_d = IDLE;
      end
    endcase
    // An aborted update reports nothing.
    if (kill) begin
      st_d  = IDLE;
      done  = 1'b0;
      error = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q  <= IDLE;
      nrn_q <= '0;
      ltp_q <= 1'b0;
      dt_q  <= '0;
      w_q   <= '0;
      new_q <= '0;
      tmo_q <= '0;
    end else begin
      st_q <= st_d;
      if (accept) begin
        nrn_q <= bus.upd_neuron;
        ltp_q <= bus.upd_ltp;
        dt_q  <= bus.upd_dt;
      end
      if (st_q == RD_REQ) begin
        tmo_q <= '0;
      end else if (st_q == RD_WAIT && !bus.rd_valid) begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (st_q == RD_WAIT && bus.rd_valid) begin
        w_q <= bus.rd_weight;
      end
      // wr_weight only moves when a write is actually going out.
      if (st_q == CALC && step != 8'd0 && !kill) begin
        new_q <= new_w;
      end
    end
  end

`ifdef STDP_UPD_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (st_q == WR && bus.wr_ack && !kill) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign upd_count = cnt_q;
`else
  assign upd_count = '0;
`endif

endmodule

// File: tb/tb_stdp_weight_writer.sv
// Directed bench for stdp_weight_writer.
// Drives at posedge+1, checks once combinational outputs settle.
module tb_stdp_weight_writer;

  logic        clk;
  logic        rst;
  logic        kill;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] upd_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

`ifdef STDP_UPD_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  stdp_weight_writer_if bus ();

  stdp_weight_writer dut (
    .clk       (clk),
    .rst       (rst),
    .kill      (kill),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .upd_count (upd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Runs one full update with immediate rd_valid and wr_ack.
  task automatic run_upd(
    input  logic [6:0] n,
    input  logic       l,
    input  logic [3:0] d,
    input  logic [7:0] w,
    output bit         sw,
    output logic [7:0] ww,
    output bit         sd
  );
    sw = 1'b0;
    sd = 1'b0;
    ww = 8'hxx;
    bus.upd_neuron = n;
    bus.upd_ltp    = l;
    bus.upd_dt     = d;
    bus.upd_valid  = 1'b1;
    nxt();
    bus.upd_valid = 1'b0;
    nxt();
    bus.rd_valid  = 1'b1;
    bus.rd_weight = w;
    nxt();
    bus.rd_valid = 1'b0;
    for (int i = 0; i < 4 && !sd; i++) begin
      nxt();
      if (bus.wr_req) begin
        sw = 1'b1;
        ww = bus.wr_weight;
        bus.wr_ack = 1'b1;
      end else begin
        bus.wr_ack = 1'b0;
      end
      if (done) sd = 1'b1;
    end
    bus.wr_ack = 1'b0;
    nxt();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    nxt();
    nxt();
    rst = 1'b1;
    nxt();
    n_cmp++;
    if (bus.upd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready got %b want 1", bus.upd_ready);
    end
    n_cmp++;
    if ({bus.rd_req, bus.wr_req, busy, done, error} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_flags got %b want 00000",
               {bus.rd_req, bus.wr_req, busy, done, error});
    end
    n_cmp++;
    if ({bus.rd_neuron, bus.wr_neuron, bus.wr_weight} !== 22'd0) begin
      n_bad++;
      $display("FAIL rst_data got %h/%h/%h want 0/0/0",
               bus.rd_neuron, bus.wr_neuron, bus.wr_weight);
    end
    n_cmp++;
    if (upd_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_count got %h want 0000", upd_count);
    end
  endtask

  task automatic test_ltp_basic();
    bus.upd_neuron = 7'd5;
    bus.upd_ltp    = 1'b1;
    bus.upd_dt     = 4'd1;
    bus.upd_valid  = 1'b1;
    #1;
    n_cmp++;
    if (bus.upd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL c0_ready got %b want 1", bus.upd_ready);
    end
    nxt();
    bus.upd_valid = 1'b0;
    n_cmp++;
    if (bus.rd_req !== 1'b1 || bus.rd_neuron !== 7'd5 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL c1_rd got req=%b n=%0d busy=%b want 1/5/1",
               bus.rd_req, bus.rd_neuron, busy);
    end
    nxt();
    bus.rd_valid  = 1'b1;
    bus.rd_weight = 8'd100;
    n_cmp++;
    if (bus.rd_req !== 1'b0) begin
      n_bad++;
      $display("FAIL c2_rdreq got %b want 0", bus.rd_req);
    end
    nxt();
    bus.rd_valid = 1'b0;
    n_cmp++;
    if (bus.wr_req !== 1'b0) begin
      n_bad++;
      $display("FAIL c3_wrreq got %b want 0", bus.wr_req);
    end
    nxt();
    bus.wr_ack = 1'b1;
    n_cmp++;
    if (bus.wr_req !== 1'b1 || bus.wr_neuron !== 7'd5 ||
        bus.wr_weight !== 8'd116) begin
      n_bad++;
      $display("FAIL c4_wr got req=%b n=%0d w=%0d want 1/5/116",
               bus.wr_req, bus.wr_neuron, bus.wr_weight);
    end
    nxt();
    bus.wr_ack = 1'b0;
    exp_cnt++;
    n_cmp++;
    if (done !== 1'b1 || bus.wr_req !== 1'b0) begin
      n_bad++;
      $display("FAIL c5_done got done=%b wr=%b want 1/0", done, bus.wr_req);
    end
    nxt();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.upd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL c6_idle got done=%b busy=%b rdy=%b want 0/0/1",
               done, busy, bus.upd_ready);
    end
    n_cmp++;
    if (upd_count !== (CNT_EN ? 16'(exp_cnt) : 16'd0)) begin
      n_bad++;
      $display("FAIL c6_count got %h want %h", upd_count,
               CNT_EN ? 16'(exp_cnt) : 16'd0);
    end
  endtask

  task automatic test_saturation();
    bit sw, sd;
    logic [7:0] ww;
    logic [6:0] nv [4] = '{7'd7, 7'd9, 7'd3, 7'd12};
    logic       lv [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] dv [4] = '{4'd0, 4'd0, 4'd2, 4'd3};
    logic [7:0] wv [4] = '{8'd250, 8'd10, 8'd100, 8'd251};
    logic [7:0] ev [4] = '{8'd255, 8'd0, 8'd96, 8'd255};
    for (int i = 0; i < 4; i++) begin
      run_upd(nv[i], lv[i], dv[i], wv[i], sw, ww, sd);
      exp_cnt++;
      n_cmp++;
      if (sw !== 1'b1 || sd !== 1'b1 || ww !== ev[i]) begin
        n_bad++;
        $display("FAIL sat%0d got wr=%b done=%b w=%0d want 1/1/%0d",
                 i, sw, sd, ww, ev[i]);
      end
    end
    n_cmp++;
    if (upd_count !== (CNT_EN ? 16'(exp_cnt) : 16'd0)) begin
      n_bad++;
      $display("FAIL sat_count got %h want %h", upd_count,
               CNT_EN ? 16'(exp_cnt) : 16'd0);
    end
  endtask

  task automatic test_zero_step();
    bit sw, sd;
    logic [7:0] ww;
    run_upd(7'd2, 1'b1, 4'd9, 8'd50, sw, ww, sd);
    n_cmp++;
    if (sw !== 1'b0 || sd !== 1'b1) begin
      n_bad++;
      $display("FAIL zs_dt9 got wr=%b done=%b want 0/1", sw, sd);
    end
    run_upd(7'd2, 1'b0, 4'd5, 8'd50, sw, ww, sd);
    n_cmp++;
    if (sw !== 1'b0 || sd !== 1'b1) begin
      n_bad++;
      $display("FAIL zs_ltd5 got wr=%b done=%b want 0/1", sw, sd);
    end
    n_cmp++;
    if (upd_count !== (CNT_EN ? 16'(exp_cnt) : 16'd0)) begin
      n_bad++;
      $display("FAIL zs_count got %h want %h", upd_count,
               CNT_EN ? 16'(exp_cnt) : 16'd0);
    end
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    bit sw = 1'b0;
    bus.upd_neuron = 7'd4;
    bus.upd_ltp    = 1'b1;
    bus.upd_dt     = 4'd0;
    bus.upd_valid  = 1'b1;
    nxt();
    bus.upd_valid = 1'b0;
    nxt();
    for (int i = 0; i < 14; i++) begin
      if (error !== 1'b0) early = 1'b1;
      if (bus.wr_req !== 1'b0) sw = 1'b1;
      nxt();
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_early got 1 want 0");
    end
    n_cmp++;
    if (error !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_err got %b want 1", error);
    end
    nxt();
    n_cmp++;
    if (error !== 1'b0 || busy !== 1'b0 || bus.upd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_idle got err=%b busy=%b rdy=%b want 0/0/1",
               error, busy, bus.upd_ready);
    end
    n_cmp++;
    if (sw !== 1'b0 || bus.wr_req !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_nowr got %b want 0", sw | bus.wr_req);
    end
  endtask

  task automatic test_kill_wr();
    bus.upd_neuron = 7'd6;
    bus.upd_ltp    = 1'b1;
    bus.upd_dt     = 4'd1;
    bus.upd_valid  = 1'b1;
    nxt();
    bus.upd_valid = 1'b0;
    nxt();
    bus.rd_valid  = 1'b1;
    bus.rd_weight = 8'd100;
    nxt();
    bus.rd_valid = 1'b0;
    nxt();
    nxt();
    n_cmp++;
    if (bus.wr_req !== 1'b1 || bus.wr_weight !== 8'd116) begin
      n_bad++;
      $display("FAIL kw_hold got req=%b w=%0d want 1/116",
               bus.wr_req, bus.wr_weight);
    end
    kill = 1'b1;
    nxt();
    n_cmp++;
    if (bus.wr_req !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL kw_abort got wr=%b done=%b busy=%b want 0/0/0",
               bus.wr_req, done, busy);
    end
    kill = 1'b0;
    nxt();
    n_cmp++;
    if (done !== 1'b0 ||
        upd_count !== (CNT_EN ? 16'(exp_cnt) : 16'd0)) begin
      n_bad++;
      $display("FAIL kw_after got done=%b cnt=%h want 0/%h", done,
               upd_count, CNT_EN ? 16'(exp_cnt) : 16'd0);
    end
  endtask

  task automatic test_kill_accept();
    kill = 1'b1;
    bus.upd_valid  = 1'b1;
    bus.upd_neuron = 7'd8;
    #1;
    n_cmp++;
    if (bus.upd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ka_ready got %b want 0", bus.upd_ready);
    end
    nxt();
    bus.upd_valid = 1'b0;
    kill = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || bus.rd_req !== 1'b0) begin
      n_bad++;
      $display("FAIL ka_idle got busy=%b rd=%b want 0/0", busy, bus.rd_req);
    end
  endtask

  task automatic test_back_to_back();
    bus.upd_neuron = 7'd10;
    bus.upd_ltp    = 1'b1;
    bus.upd_dt     = 4'd1;
    bus.upd_valid  = 1'b1;
    nxt();
    bus.upd_valid = 1'b0;
    nxt();
    bus.rd_valid  = 1'b1;
    bus.rd_weight = 8'd100;
    nxt();
    bus.rd_valid = 1'b0;
    nxt();
    bus.wr_ack = 1'b1;
    nxt();
    bus.wr_ack = 1'b0;
    exp_cnt++;
    bus.upd_neuron = 7'd11;
    bus.upd_valid  = 1'b1;
    #1;
    n_cmp++;
    if (done !== 1'b1 || bus.upd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_fin got done=%b rdy=%b want 1/0",
               done, bus.upd_ready);
    end
    nxt();
    n_cmp++;
    if (bus.upd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready got %b want 1", bus.upd_ready);
    end
    nxt();
    bus.upd_valid = 1'b0;
    n_cmp++;
    if (bus.rd_req !== 1'b1 || bus.rd_neuron !== 7'd11) begin
      n_bad++;
      $display("FAIL b2b_rd got req=%b n=%0d want 1/11",
               bus.rd_req, bus.rd_neuron);
    end
    kill = 1'b1;
    nxt();
    kill = 1'b0;
    nxt();
  endtask

`ifdef STDP_UPD_COUNT_EN
  task automatic test_count_wrap();
    bit sw, sd;
    logic [7:0] ww;
    dut.cnt_q = 16'hFFFF;
    run_upd(7'd1, 1'b1, 4'd1, 8'd100, sw, ww, sd);
    exp_cnt = 0;
    n_cmp++;
    if (sw !== 1'b1 || upd_count !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap got wr=%b cnt=%h want 1/0000", sw, upd_count);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bus.upd_neuron = 7'd20;
    bus.upd_ltp    = 1'b0;
    bus.upd_dt     = 4'd0;
    bus.upd_valid  = 1'b1;
    nxt();
    bus.upd_valid = 1'b0;
    nxt();
    rst = 1'b0;
    nxt();
    exp_cnt = 0;
    n_cmp++;
    if ({bus.rd_req, bus.wr_req, busy, done, error} !== 5'b0 ||
        bus.upd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_flags got %b rdy=%b want 00000/1",
               {bus.rd_req, bus.wr_req, busy, done, error}, bus.upd_ready);
    end
    n_cmp++;
    if ({bus.rd_neuron, bus.wr_neuron, bus.wr_weight} !== 22'd0 ||
        upd_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rmid_data got %h/%h/%h cnt=%h want 0",
               bus.rd_neuron, bus.wr_neuron, bus.wr_weight, upd_count);
    end
    rst = 1'b1;
    nxt();
  endtask

  initial begin
    rst            = 1'b0;
    kill           = 1'b0;
    bus.upd_valid  = 1'b0;
    bus.upd_neuron = '0;
    bus.upd_ltp    = 1'b0;
    bus.upd_dt     = '0;
    bus.rd_valid   = 1'b0;
    bus.rd_weight  = '0;
    bus.wr_ack     = 1'b0;
    test_reset();
    test_ltp_basic();
    test_saturation();
    test_zero_step();
    test_timeout();
    test_kill_wr();
    test_kill_accept();
    test_back_to_back();
`ifdef STDP_UPD_COUNT_EN
    test_count_wrap();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
